// File: rtl/turn_signal_conditioner.sv
// Turn-signal input conditioner: 2-flop sync, per-channel debounce, break-before-make FSM.
// Optional macro HAZARD_TAILLIGHT_EN: both stable requests select HAZARD instead of IDLE.
module turn_signal_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    output logic       left_out,
    output logic       right_out,
    output logic [1:0] state
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        HAZARD = 2'b11
    } state_t;

    // Channel index 0 is left, 1 is right.
    logic [1:0]         sync1, sync2, stable;
    logic [1:0][CW-1:0] cnt;
    state_t             cur, target, nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {right, left};
            sync2 <= sync1;
        end
    end

    // A disagreement must persist DEBOUNCE_CYCLES edges before stable flips;
    // any agreement in between restarts the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stable <= '0;
            cnt    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        target = IDLE;
        case (stable)
            2'b01:   target = LEFT;
            2'b10:   target = RIGHT;
`ifdef HAZARD_TAILLIGHT_EN
            2'b11:   target = HAZARD;
`else
            2'b11:   target = IDLE;
`endif
            default: target = IDLE;
        endcase
        // Any change between two active states goes through one IDLE cycle.
        nxt = target;
        if (cur != IDLE && target != IDLE && target != cur)
            nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur       <= IDLE;
            left_out  <= 1'b0;
            right_out <= 1'b0;
        end else begin
            cur       <= nxt;
            left_out  <= (nxt == LEFT)  || (nxt == HAZARD);
            right_out <= (nxt == RIGHT) || (nxt == HAZARD);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Directed bench for turn_signal_conditioner at DEBOUNCE_CYCLES=4 (7-edge latency).
module tb_turn_signal_conditioner;

    logic       clk;
    logic       reset;
    logic       left;
    logic       right;
    logic       left_out;
    logic       right_out;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;

`ifdef HAZARD_TAILLIGHT_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif
    localparam logic [1:0] BOTH_ST  = HZ ? 2'b11 : 2'b00;
    localparam logic [1:0] BOTH_OUT = HZ ? 2'b11 : 2'b00;

    turn_signal_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .left      (left),
        .right     (right),
        .left_out  (left_out),
        .right_out (right_out),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // outs packs {left_out, right_out}
    task automatic chk_all(input string tag, input logic [1:0] exp_st, input logic [1:0] exp_out);
        chk({tag, " state"}, state, exp_st);
        chk({tag, " outs"}, {left_out, right_out}, exp_out);
    endtask

    initial begin
        reset = 1'b0;
        left  = 1'b1;
        right = 1'b1;

        // Reset held two cycles with both switches on
        step(); chk_all("rst_e1", 2'b00, 2'b00);
        step(); chk_all("rst_e2", 2'b00, 2'b00);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(); chk_all("post_rst_wait", 2'b00, 2'b00);
        end
        step(); chk_all("post_rst_e7", BOTH_ST, BOTH_OUT);

        // Clean return to idle
        left = 1'b0; right = 1'b0; reset = 1'b0;
        step(); step();
        reset = 1'b1;
        step(); chk_all("idle_clean", 2'b00, 2'b00);

        // Left held: rises on edge 7
        left = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(); chk_all("left_wait", 2'b00, 2'b00);
        end
        step(); chk_all("left_e7", 2'b01, 2'b10);

        // Left -> right swap: one IDLE cycle in between
        left = 1'b0; right = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(); chk_all("swap_hold_left", 2'b01, 2'b10);
        end
        step(); chk_all("swap_idle", 2'b00, 2'b00);
        step(); chk_all("swap_right", 2'b10, 2'b01);

        right = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(); chk_all("right_hold", 2'b10, 2'b01);
        end
        step(); chk_all("right_release", 2'b00, 2'b00);

        // 3-cycle glitch on left is rejected
        left = 1'b1;
        step(); step(); step();
        left = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(); chk_all("glitch", 2'b00, 2'b00);
        end

        // Both from IDLE
        left = 1'b1; right = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(); chk_all("both_wait", 2'b00, 2'b00);
        end
        step(); chk_all("both_e7", BOTH_ST, BOTH_OUT);
        left = 1'b0; right = 1'b0;
        for (int k = 1; k <= 7; k++) step();
        chk_all("both_release", 2'b00, 2'b00);

        // Reset mid-debounce (count 2) on right
        right = 1'b1;
        step(); step(); step(); step();
        reset = 1'b0;
        step(); chk_all("rst_mid_debounce", 2'b00, 2'b00);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(); chk_all("rst_redebounce_wait", 2'b00, 2'b00);
        end
        step(); chk_all("rst_redebounce_e7", 2'b10, 2'b01);

        // Reset while in RIGHT state
        reset = 1'b0; right = 1'b0;
        step(); chk_all("rst_mid_state", 2'b00, 2'b00);
        reset = 1'b1;
        step(); step();
        chk_all("rst_mid_state_after", 2'b00, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/turn_signal_conditioner.md
TURN_SIGNAL_CONDITIONER -- requirements
Module: turn_signal_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, number of consecutive clk cycles a synchronized input must differ from its stable value before the stable value changes; legal range 2..65535.
REQ-002 Port: clk  input  1  system clock; the single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-004 Port: left  input  1  raw, asynchronous left-turn switch, active-high.
REQ-005 Port: right  input  1  raw, asynchronous right-turn switch, active-high.
REQ-006 Port: left_out  output  1  registered, debounced left request to the taillight sequencer.
REQ-007 Port: right_out  output  1  registered, debounced right request to the taillight sequencer.
REQ-008 Port: state  output  2  current FSM state: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD.

Function
REQ-009 Each raw input SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-010 Each channel SHALL hold a stable bit and a debounce counter sized for DEBOUNCE_CYCLES-1.
REQ-011 Synchronized value equal to stable: counter SHALL clear to 0.
REQ-012 Synchronized value differing from stable: counter SHALL increment; on the cycle it reaches DEBOUNCE_CYCLES-1 while still differing, stable SHALL invert on the next edge and counter SHALL clear.
REQ-013 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave stable unchanged and reset the count.
REQ-014 FSM next state from stable pair (L,R): (0,0) -> IDLE; (1,0) -> LEFT; (0,1) -> RIGHT; (1,1) -> per REQ-022/023.
REQ-015 Direct LEFT<->RIGHT transition SHALL NOT occur: FSM SHALL spend exactly one cycle in IDLE before entering the opposite direction (break-before-make).
REQ-016 Same break-before-make SHALL apply to LEFT/RIGHT -> HAZARD and HAZARD -> LEFT/RIGHT.
REQ-017 Outputs SHALL be registered decodes of state: IDLE 0/0, LEFT 1/0, RIGHT 0/1, HAZARD 1/1 (left_out/right_out).
REQ-018 Latency: a clean raw edge held steady SHALL reach left_out/right_out exactly DEBOUNCE_CYCLES+3 clk edges after the first edge that samples it (2 sync + DEBOUNCE_CYCLES debounce + 1 FSM), plus 1 if the break-before-make cycle applies.
REQ-019 Channels SHALL debounce independently; simultaneous raw edges on both SHALL stabilize on the same cycle.
REQ-020 left_out and right_out SHALL never glitch; they change only on clk edges.

Reset
REQ-021 reset=0 at a clk edge SHALL force synchronizer flops, stable bits, counters to 0, state to IDLE, left_out=0, right_out=0 on that edge, including mid-debounce and mid-state; release resumes from those values with no pending transition.

Configuration
REQ-022 Macro HAZARD_TAILLIGHT_EN defined: stable (1,1) SHALL select HAZARD, driving left_out=1 and right_out=1.
REQ-023 Macro HAZARD_TAILLIGHT_EN undefined: stable (1,1) SHALL select IDLE (both outputs 0); HAZARD state SHALL be unreachable and state never reads 11.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-024 reset=0 two cycles with left=right=1 -> state=00, left_out=right_out=0 throughout; after release, left_out=1 exactly 7 edges later (macro undefined: stays 0 as (1,1)).
REQ-025 left 0->1 held -> left_out rises on edge 7; left pulse of 3 cycles -> left_out stays 0.
REQ-026 left=1 settled, then left=0 and right=1 same cycle -> state LEFT, then one IDLE cycle, then RIGHT; left_out and right_out never both 1.
REQ-027 Macro defined, left=right=1 from IDLE -> state=11, both outputs 1 on edge 7; macro undefined -> state stays 00.
REQ-028 reset=0 asserted at debounce count 2 with right rising -> outputs 0 on that edge; after release, right_out needs full 7 edges again.
